serial_divider: RTL and testbench
=================================

Name: serial_divider

Overview:
- Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU, instantiated inside the execute-stage ALU.
- The ALU drives start and signed_div and holds the pipeline stalled until ready pulses.
- The ALU then forwards result as {HI=remainder, LO=quotient} to the HI/LO write path.
- Exactly one operation in flight; no pipelining.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- ITER, WIDTH, number of restoring iterations; must equal WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  request; the ALU holds it high while ready=0 for a div op, and drops it combinationally when ready=1.
- signed_div  input  1  1=DIV (two's complement), 0=DIVU; sampled with start.
- a  input  WIDTH  dividend; sampled at the accepting edge.
- b  input  WIDTH  divisor; sampled at the accepting edge.
- annul  input  1  abort the current operation (exception/flush).
- result  output  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}; registered.
- ready  output  1  one-cycle pulse; result is valid and final in that cycle.

Behaviour:
- Reset (resetn=0, async, any state): state=IDLE, ready=0, result=0, counter=0, operand regs=0. Takes effect immediately, mid-operation included.
- States: IDLE, BUSY, FIX, DONE.
- IDLE: if start=1 and annul=0 at an edge (E0):
  - latch signed_div, the sign of a, and the sign of b;
  - latch |a| and |b| when signed_div=1, otherwise raw a and b;
  - clear partial remainder and counter; go to BUSY.
- IDLE with start=1 and annul=1: not accepted; stay in IDLE.
- BUSY: one restoring step per edge.
  - {rem,quo} shifted left 1; trial = rem - divisor (WIDTH+1 bits).
  - If trial is non-negative: rem=trial, quo LSB=1; otherwise restore, quo LSB=0.
  - Counter increments each step; after ITER steps (edges E1..E32) go to FIX.
- FIX (edge E33): register the sign-corrected result and go to DONE.
  - Signed quotient is negated if sign(a) XOR sign(b) and b≠0.
  - Signed remainder is negated if sign(a)=1.
- DONE: ready=1 for exactly this cycle, which is the 34th cycle counting the accepting cycle as 0. Next edge returns to IDLE unconditionally.
  - start is ignored in DONE; a new request is accepted from IDLE only.
- ready=0 in every state except DONE.
- result holds its last value from DONE until the next FIX edge. It is never cleared except by reset.
- annul=1 at any edge in BUSY or FIX: go to IDLE and discard work. ready stays 0 and result is unchanged.
- annul in DONE: ready is already high this cycle; go to IDLE as normal. Consuming or discarding the result is the ALU's concern.
- Inputs a, b and signed_div may change after E0 without effect.
- Divide by zero (defined, non-trapping, full 34-cycle latency):
  - quotient=all-ones, remainder=a (original signed/unsigned value).
  - Both signed and unsigned modes give this result; no sign fix is applied to the quotient.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0. Falls out naturally from the |x| datapath with WIDTH+1-bit trial subtraction.
- Absolute value of 0x80000000 is 0x80000000 treated as unsigned; no extra width is needed.
- Back-to-back: after DONE→IDLE, a start high in IDLE is accepted at that edge. Minimum spacing between ready pulses is 35 cycles.

Decomposition:
- Shared package/include (alongside the ALU defines):
  - DIV_ITER = 32;
  - state encodings DIV_IDLE=2'd0, DIV_BUSY=2'd1, DIV_FIX=2'd2, DIV_DONE=2'd3;
  - result field positions (HI = [63:32], LO = [31:0]).
- One natural sub-module: div_restore_step. It is purely combinational: takes {rem, quo, divisor} and returns the next {rem, quo}. This allows later unrolling to radix-4 by instantiating it twice per cycle.

Test Plan:
- Unsigned 100/7, start held until ready: ready pulses in cycle 34 only; result={32'd2, 32'd14}; after ALU drops start, no second pulse.
- Signed -7/2 (a=0xFFFFFFF9, b=2): result={0xFFFFFFFF, 0xFFFFFFFD}. Signed 7/-2: result={0x00000001, 0xFFFFFFFD}.
- Signed 0x80000000 / 0xFFFFFFFF: result={0x00000000, 0x80000000}. Unsigned 0xFFFFFFFF/1: result={0, 0xFFFFFFFF}.
- Divide by zero: DIVU 5/0 gives {0x00000005, 0xFFFFFFFF}; DIV -5/0 gives {0xFFFFFFFB, 0xFFFFFFFF}; both have ready in cycle 34.
- annul asserted in cycle 10 of an operation: state IDLE next cycle; ready never rises; result keeps its previous value. A new start 1 cycle later completes correctly 34 cycles after acceptance.
- resetn pulled low in cycle 20 (mid-edge, asynchronously): ready=0 and result=0 immediately. After release, 9/3 returns {0, 3} with normal latency. Back-to-back ops give ready pulses 35 cycles apart.

Source files
------------

// File: rtl/serial_divider_pkg.sv
// Shared definitions for the execute-stage serial divider.
// State encodings, iteration count and HI/LO result field positions.
package serial_divider_pkg;

    localparam int DIV_W    = 32;
    localparam int DIV_ITER = 32;

    localparam int DIV_HI_MSB = 63;
    localparam int DIV_HI_LSB = 32;
    localparam int DIV_LO_MSB = 31;
    localparam int DIV_LO_LSB = 0;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step, purely combinational.
// Chaining two instances per cycle gives a radix-4 divider.
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shl;
    logic [WIDTH:0] trial;
    logic           neg;

    // rem < divisor holds between steps, so WIDTH+1 bits never overflow
    assign shl   = {rem_i, quo_i[WIDTH-1]};
    assign trial = shl - {1'b0, dvs_i};
    assign neg   = trial[WIDTH];

    assign rem_o = neg ? shl[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_o = {quo_i[WIDTH-2:0], ~neg};

endmodule

// File: rtl/serial_divider.sv
// Multi-cycle restoring divider for DIV/DIVU in the execute-stage ALU.
// result = {remainder, quotient}; ready pulses one cycle in DONE.
module serial_divider
    import serial_divider_pkg::*;
#(
    parameter int WIDTH = DIV_W,
    parameter int ITER  = WIDTH
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready
);

    localparam int CW = $clog2(ITER + 1);

    div_state_t state_q, state_d;

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               sgn_q, sgn_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic [2*WIDTH-1:0] res_q, res_d;

    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic             neg_quo;
    logic             neg_rem;

    div_restore_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // |MIN| wraps to MIN, which is the correct unsigned magnitude
    assign a_abs = (signed_div && a[WIDTH-1]) ? -a : a;
    assign b_abs = (signed_div && b[WIDTH-1]) ? -b : b;

    // Divide by zero leaves quotient all-ones and rem = |a|; the
    // remainder sign fix then restores the original a
    assign neg_quo = sgn_q & (sa_q ^ sb_q) & (|dvs_q);
    assign neg_rem = sgn_q & sa_q;
    assign quo_fix = neg_quo ? -quo_q : quo_q;
    assign rem_fix = neg_rem ? -rem_q : rem_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        sgn_d   = sgn_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (start && !annul) begin
                    sgn_d   = signed_div;
                    sa_d    = a[WIDTH-1];
                    sb_d    = b[WIDTH-1];
                    quo_d   = a_abs;
                    dvs_d   = b_abs;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                if (annul) begin
                    state_d = DIV_IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(ITER - 1)) begin
                        state_d = DIV_FIX;
                    end
                end
            end
            DIV_FIX: begin
                if (annul) begin
                    state_d = DIV_IDLE;
                end else begin
                    res_d   = {rem_fix, quo_fix};
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            sgn_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            sgn_q   <= sgn_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
        end
    end

    assign result = res_q;
    assign ready  = (state_q == DIV_DONE);

endmodule

// File: tb/tb_serial_divider.sv
// Randomised bench for serial_divider against a cycle-count model.
// Model: quotient/remainder from plain arithmetic, 34-cycle latency.
module tb_serial_divider;
    import serial_divider_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic        annul = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [63:0] result;
    logic        ready;

    int n_chk = 0;
    int n_pass = 0;

    serial_divider #(
        .WIDTH (32),
        .ITER  (32)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .annul      (annul),
        .result     (result),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, got, want);
    endtask

    function automatic logic [63:0] ref_div(input bit sd,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
        int q;
        int r;
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (!sd) return {x % y, x / y};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
            return {32'h0, 32'h8000_0000};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
    endfunction

    // Behavioural model: accepted op finishes 34 cycles later
    bit          m_busy = 0;
    bit          m_rdy = 0;
    int          m_left = 0;
    logic [63:0] m_res = '0;
    logic [63:0] m_pend = '0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_busy = 0;
            m_rdy  = 0;
            m_left = 0;
            m_res  = '0;
        end else if (m_rdy) begin
            m_rdy = 0;
        end else if (m_busy) begin
            if (annul) begin
                m_busy = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_rdy  = 1;
                    m_res  = m_pend;
                end
            end
        end else if (start && !annul) begin
            m_busy = 1;
            m_left = 33;
            m_pend = ref_div(signed_div, a, b);
        end
    end

    always @(negedge clk) begin
        chk("ready", 64'(ready), 64'(m_rdy));
        chk("result", result, m_res);
    end

    // Called at posedge+2; returns at posedge+2 of the ready cycle
    task automatic run_op(input bit sd, input logic [31:0] x,
                          input logic [31:0] y, input int exp_lat,
                          output logic [63:0] got);
        int n;
        bit seen;
        signed_div = sd;
        a = x;
        b = y;
        start = 1'b1;
        n = 0;
        seen = 0;
        while (!seen && n < 100) begin
            @(posedge clk);
            #2;
            n++;
            if (ready) seen = 1;
        end
        start = 1'b0;
        got = result;
        chk("latency", 64'(n), 64'(exp_lat));
        a = $urandom;
        b = $urandom;
        signed_div = 1'($urandom);
    endtask

    task automatic idle1();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        logic [31:0] x;
        logic [31:0] y;
        int pulses;
        bit sd;

        chk("pin_model_neg7_2", ref_div(1, 32'hFFFF_FFF9, 32'd2),
            64'hFFFF_FFFF_FFFF_FFFD);
        chk("pin_model_divu0", ref_div(0, 32'd5, 32'd0),
            64'h0000_0005_FFFF_FFFF);

        #1 resetn = 1'b0;
        #1;
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_result", result, 64'd0);
        repeat (3) @(posedge clk);
        #3 resetn = 1'b1;
        idle1();

        run_op(0, 32'd100, 32'd7, 34, r);
        chk("divu_100_7", r, {32'd2, 32'd14});
        pulses = 0;
        repeat (40) begin
            idle1();
            if (ready) pulses++;
        end
        chk("no_repulse", 64'(pulses), 64'd0);

        run_op(1, 32'hFFFF_FFF9, 32'd2, 34, r);
        chk("div_neg7_2", r, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        idle1();
        run_op(1, 32'd7, 32'hFFFF_FFFE, 34, r);
        chk("div_7_neg2", r, {32'h0000_0001, 32'hFFFF_FFFD});
        run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 35, r);
        chk("div_ovf", r, {32'h0, 32'h8000_0000});
        run_op(0, 32'hFFFF_FFFF, 32'd1, 35, r);
        chk("divu_max_1", r, {32'h0, 32'hFFFF_FFFF});
        idle1();
        run_op(0, 32'd5, 32'd0, 34, r);
        chk("divu_5_0", r, {32'h0000_0005, 32'hFFFF_FFFF});
        idle1();
        run_op(1, 32'hFFFF_FFFB, 32'd0, 34, r);
        chk("div_neg5_0", r, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
        idle1();

        signed_div = 1'b0;
        a = 32'd1000;
        b = 32'd3;
        start = 1'b1;
        repeat (10) idle1();
        annul = 1'b1;
        start = 1'b0;
        idle1();
        annul = 1'b0;
        chk("annul_idle", 64'(dut.state_q), 64'(DIV_IDLE));
        chk("annul_ready", 64'(ready), 64'd0);
        chk("annul_result", result, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
        run_op(0, 32'd1000, 32'd3, 34, r);
        chk("after_annul", r, {32'd1, 32'd333});
        idle1();

        signed_div = 1'b0;
        a = 32'd123456;
        b = 32'd7;
        start = 1'b1;
        repeat (20) idle1();
        #1 resetn = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(ready), 64'd0);
        chk("mid_rst_result", result, 64'd0);
        chk("mid_rst_idle", 64'(dut.state_q), 64'(DIV_IDLE));
        start = 1'b0;
        #3 resetn = 1'b1;
        idle1();
        run_op(0, 32'd9, 32'd3, 34, r);
        chk("divu_9_3", r, {32'd0, 32'd3});

        for (int i = 0; i < 40; i++) begin
            int mode;
            mode = $urandom_range(0, 7);
            sd = 1'($urandom);
            x = $urandom;
            y = $urandom;
            if (mode == 0) y = 0;
            else if (mode == 1) y = $urandom_range(1, 17);
            else if (mode == 2) y = -$urandom_range(1, 17);
            else if (mode == 3) x = 32'h8000_0000;
            else if (mode == 4) y = x >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) begin
                idle1();
                run_op(sd, x, y, 34, r);
            end else begin
                run_op(sd, x, y, 35, r);
            end
        end

        repeat (3) idle1();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
